// File: rtl/cordic_fix2float.sv
// Serial fixed-point (two's complement, FRAC_BITS fractional bits) to IEEE-754 single converter.
// One normalising shift per enabled cycle, then round-to-nearest-even; start/done handshake.
module cordic_fix2float #(
    parameter int unsigned FRAC_BITS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(127 + 31 - FRAC_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mag_q;
    logic [EXP_W-1:0]    exp_q;
    logic                sign_q;
    logic                done_q;
    logic [DATA_W-1:0]   result_q;

    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [MAN_W:0]      mant_sum;
    logic [EXP_W-1:0]    exp_rnd;

    // Rounding of the normalised magnitude; a carry out of the mantissa bumps the exponent
    always_comb begin
        guard    = mag_q[7];
        sticky   = |mag_q[6:0];
        round_up = guard & (sticky | mag_q[8]);
        mant_sum = {1'b0, mag_q[30:8]} + {{MAN_W{1'b0}}, round_up};
        exp_rnd  = exp_q + {{(EXP_W-1){1'b0}}, mant_sum[MAN_W]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mag_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_q  <= dataa[31];
                        // Negating 0x80000000 wraps back to 0x80000000, the correct magnitude
                        mag_q   <= dataa[31] ? DATA_W'(-dataa) : dataa;
                        exp_q   <= EXP_INIT;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (mag_q == '0) begin
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (mag_q[31]) begin
                        state_q <= S_ROUND;
                    end else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end
                end
                S_ROUND: begin
                    result_q <= {sign_q, exp_rnd, mant_sum[MAN_W-1:0]};
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Directed self-checking bench for cordic_fix2float: values, latency, stall, ignored start, reset abort.
module tb_cordic_fix2float;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    cordic_fix2float #(.FRAC_BITS(30)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact real value via double precision, then RNE down to single
    function automatic logic [31:0] ref_sp(input logic [31:0] d);
        int          si;
        real         r;
        logic [63:0] b;
        logic [7:0]  e8;
        logic [22:0] f;
        logic [28:0] rem;
        logic        up;
        si = signed'(d);
        r  = real'(si) / 1073741824.0;
        if (si == 0) return 32'h0;
        b   = $realtobits(r);
        e8  = 8'(b[62:52] - 11'd896);
        f   = b[51:29];
        rem = b[28:0];
        up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && f[0]);
        return {b[63], 31'({e8, f}) + 31'(up)};
    endfunction

    // Called at a negedge with the DUT idle; lat is the cycle index in which done is seen
    task automatic convert(input logic [31:0] d, output logic [31:0] res, output int lat);
        dataa = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int c = 2; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
        end
        @(posedge clk);
        #1 chk("done_single_pulse", 32'(done), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] res;
    int          lat;
    int          ndone;
    logic [31:0] v;

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'h0);
        reset = 1'b0;

        // Directed vectors; lat = -1 means latency not checked
        vecs.push_back('{32'h4000_0000, 32'h3F80_0000, 4});
        vecs.push_back('{32'hC000_0000, 32'hBF80_0000, -1});
        vecs.push_back('{32'h8000_0000, 32'hC000_0000, 3});
        vecs.push_back('{32'h0000_0001, 32'h3080_0000, 34});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 2});
        vecs.push_back('{32'h4000_0040, 32'h3F80_0000, -1});
        vecs.push_back('{32'h4000_00C0, 32'h3F80_0002, -1});
        vecs.push_back('{32'h7FFF_FFFF, 32'h4000_0000, -1});
        vecs.push_back('{32'h2000_0000, 32'h3F00_0000, 5});
        foreach (vecs[i]) begin
            convert(vecs[i].din, res, lat);
            chk($sformatf("value_%08h", vecs[i].din), res, vecs[i].dout);
            if (vecs[i].lat >= 0)
                chk($sformatf("latency_%08h", vecs[i].din), 32'(lat), 32'(vecs[i].lat));
        end

        // Sweep across [cos(1), 1] against the real-arithmetic model
        for (int i = 0; i < 8; i++) begin
            v = 32'h2295_0000 + 32'(i) * 32'h03A0_0000 + ($urandom() & 32'h0000_FFFF);
            convert(v, res, lat);
            chk($sformatf("sweep_%08h", v), res, ref_sp(v));
        end

        // Stall: clk_en low for 5 cycles during conversion of 1.0 (prior result 0x40000000 stays)
        convert(32'h7FFF_FFFF, res, lat);
        dataa = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        clk_en = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk);
            #1;
            chk("stall_result_frozen", result, 32'h4000_0000);
            chk("stall_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        clk_en = 1'b1;
        lat = -1;
        for (int c = 7; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("stall_latency", 32'(lat), 32'd9);
        chk("stall_value", result, 32'h3F80_0000);
        repeat (2) @(negedge clk);

        // Start pulsed during NORM must be ignored
        dataa = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        lat   = -1;
        res   = '0;
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            start = (c == 6);
            dataa = (c == 6) ? 32'h4000_0000 : 32'h0000_0001;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lat = c;
                res = result;
            end
        end
        start = 1'b0;
        chk("ignored_start_done_count", 32'(ndone), 32'd1);
        chk("ignored_start_latency", 32'(lat), 32'd34);
        chk("ignored_start_value", res, 32'h3080_0000);
        @(negedge clk);

        // Reset in cycle 2 of converting 1: abort, no done, result cleared
        dataa = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("reset_abort_no_done", 32'(ndone), 32'd0);
        chk("reset_abort_result", result, 32'h0);
        @(negedge clk);
        convert(32'h4000_0000, res, lat);
        chk("post_reset_value", res, 32'h3F80_0000);
        chk("post_reset_latency", 32'(lat), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
